// File: rtl/ovi_memop_bridge.sv
// ovi_memop_bridge: core-to-VPU OVI bridge with credit-gated issue, in-order memop queue and unit-stride data mover
// Ports: core issue/halt/completion; VPU issue, dispatch, completion, memop sync, load and store beat buses;
//        load buffer write port (core fills), store buffer read port (1-cycle latency); memop_done pulse; sticky err.
module ovi_memop_bridge #(
  parameter int MEMDATA_W = 512,
  parameter int SBID_W = 5,
  parameter int VL_W = 15,
  parameter int ISSUE_CREDITS = 4,
  parameter int STORE_CREDITS = 4,
  parameter int BUF_DEPTH = 32,
  parameter int PEND_DEPTH = 4,
  localparam int AW = $clog2(BUF_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 core_issue_valid,
  input  logic [31:0]          core_issue_instr,
  input  logic [VL_W-1:0]      core_issue_vl,
  input  logic [1:0]           core_issue_sew,
  input  logic [63:0]          core_issue_scalar,
  output logic                 core_halt,
  output logic                 core_completed_valid,
  output logic [63:0]          core_completed_data,
  output logic                 vpu_issue_valid,
  output logic [31:0]          vpu_issue_instr,
  output logic [63:0]          vpu_issue_scalar,
  output logic [SBID_W-1:0]    vpu_issue_sbid,
  output logic [VL_W-1:0]      vpu_issue_vl,
  output logic [1:0]           vpu_issue_sew,
  input  logic                 vpu_issue_credit,
  output logic                 vpu_dispatch_next_senior,
  output logic [SBID_W-1:0]    vpu_dispatch_sbid,
  input  logic                 vpu_completed_valid,
  input  logic [63:0]          vpu_completed_data,
  input  logic                 vpu_sync_start,
  output logic                 vpu_memop_sync_end,
  output logic [SBID_W-1:0]    vpu_memop_sbid,
  output logic                 vpu_load_valid,
  output logic [MEMDATA_W-1:0] vpu_load_data,
  output logic [4:0]           vpu_load_vreg,
  output logic [10:0]          vpu_load_el_id,
  output logic [6:0]           vpu_load_el_count,
  output logic [SBID_W-1:0]    vpu_load_sbid,
  input  logic                 vpu_store_valid,
  input  logic [MEMDATA_W-1:0] vpu_store_data,
  output logic                 vpu_store_credit,
  input  logic                 ldbuf_wr_en,
  input  logic [AW-1:0]        ldbuf_wr_addr,
  input  logic [MEMDATA_W-1:0] ldbuf_wr_data,
  input  logic [AW-1:0]        stbuf_rd_addr,
  output logic [MEMDATA_W-1:0] stbuf_rd_data,
  output logic                 memop_done,
  output logic                 err
);
  localparam int PW = $clog2(PEND_DEPTH);
  localparam int CW = $clog2(ISSUE_CREDITS + 1);
  localparam int RW = $clog2(STORE_CREDITS + 2);
  localparam int NW = VL_W + 1;
  localparam int LS = $clog2(MEMDATA_W) - 3;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STORE, ST_END} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] credits;
  logic [SBID_W-1:0] sbid;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count;
  logic [AW:0] k, k_nxt;
  logic [RW-1:0] st_owed, st_avail;
  logic st_pulse;
  logic [MEMDATA_W-1:0] ldbuf [BUF_DEPTH];
  logic [MEMDATA_W-1:0] stbuf [BUF_DEPTH];
  logic [SBID_W-1:0] q_sbid [PEND_DEPTH];
  logic [VL_W-1:0] q_vl [PEND_DEPTH];
  logic [1:0] q_sew [PEND_DEPTH];
  logic [4:0] q_vreg [PEND_DEPTH];
  logic [PEND_DEPTH-1:0] q_st;
  logic accept, is_store, is_memop, push, pop, q_empty, q_full, last, err_set;
  logic [1:0] h_sew;
  logic [VL_W-1:0] h_vl;
  logic [3:0] sh;
  logic [NW-1:0] epb, n_raw, n, eid;
  assign q_empty = count == '0;
  assign q_full = count == (PW+1)'(PEND_DEPTH);
  assign core_halt = credits == '0 || q_full;
  assign accept = core_issue_valid && !core_halt;
  assign is_store = core_issue_instr[6:0] == 7'b0100111;
  assign is_memop = is_store || core_issue_instr[6:0] == 7'b0000111;
  assign push = accept && is_memop;
  assign pop = state == ST_END;
  assign vpu_issue_valid = accept;
  assign vpu_issue_instr = accept ? core_issue_instr : '0;
  assign vpu_issue_scalar = accept ? core_issue_scalar : '0;
  assign vpu_issue_vl = accept ? core_issue_vl : '0;
  assign vpu_issue_sew = accept ? core_issue_sew : '0;
  assign vpu_issue_sbid = accept ? sbid : '0;
  assign vpu_dispatch_next_senior = accept;
  assign vpu_dispatch_sbid = accept ? sbid : '0;
  // Elements per beat is a power of two, so beat count and element ids reduce to shifts by sh = log2(EPB).
  assign h_sew = q_sew[rd_ptr];
  assign h_vl = q_vl[rd_ptr];
  assign sh = 4'(LS) - {2'b0, h_sew};
  assign epb = NW'(MEMDATA_W / 8) >> h_sew;
  assign n_raw = (NW'(h_vl) + epb - NW'(1)) >> sh;
  assign n = n_raw > NW'(BUF_DEPTH) ? NW'(BUF_DEPTH) : n_raw;
  assign eid = NW'(k) << sh;
  assign last = NW'(k) + NW'(1) == n;
  assign vpu_load_valid = state == ST_LOAD;
  assign vpu_load_data = vpu_load_valid ? ldbuf[k[AW-1:0]] : '0;
  assign vpu_load_vreg = vpu_load_valid ? q_vreg[rd_ptr] : '0;
  assign vpu_load_sbid = vpu_load_valid ? q_sbid[rd_ptr] : '0;
  assign vpu_load_el_id = vpu_load_valid ? 11'(eid) : '0;
  assign vpu_load_el_count = vpu_load_valid ? 7'(last ? NW'(h_vl) - eid : epb) : '0;
  assign vpu_memop_sync_end = pop;
  assign vpu_memop_sbid = pop ? q_sbid[rd_ptr] : '0;
  assign memop_done = pop;
  assign err_set = (vpu_store_valid && state != ST_STORE)
                || (vpu_issue_credit && !accept && credits == CW'(ISSUE_CREDITS))
                || (vpu_sync_start && state == ST_IDLE && (q_empty || n_raw > NW'(BUF_DEPTH)));
  // Owed store credits drain one per cycle; reset preloads the initial grant.
  assign st_avail = st_owed + RW'(vpu_store_valid);
  assign st_pulse = st_avail != '0;
  always_comb begin
    state_nxt = state;
    k_nxt = k;
    case (state)
      ST_IDLE: if (vpu_sync_start && !q_empty) begin
        k_nxt = '0;
        state_nxt = n == '0 ? ST_END : q_st[rd_ptr] ? ST_STORE : ST_LOAD;
      end
      ST_LOAD: begin
        k_nxt = k + (AW+1)'(1);
        state_nxt = last ? ST_END : ST_LOAD;
      end
      ST_STORE: if (vpu_store_valid) begin
        k_nxt = k + (AW+1)'(1);
        state_nxt = last ? ST_END : ST_STORE;
      end
      ST_END: state_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      k <= '0;
      credits <= CW'(ISSUE_CREDITS);
      sbid <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      st_owed <= RW'(STORE_CREDITS);
      vpu_store_credit <= 1'b0;
      core_completed_valid <= 1'b0;
      core_completed_data <= '0;
      stbuf_rd_data <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nxt;
      k <= k_nxt;
      credits <= accept && !vpu_issue_credit ? credits - CW'(1)
               : !accept && vpu_issue_credit && credits != CW'(ISSUE_CREDITS) ? credits + CW'(1)
               : credits;
      sbid <= accept ? sbid + SBID_W'(1) : sbid;
      wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      st_owed <= st_avail - RW'(st_pulse);
      vpu_store_credit <= st_pulse;
      core_completed_valid <= vpu_completed_valid;
      core_completed_data <= vpu_completed_data;
      stbuf_rd_data <= stbuf[stbuf_rd_addr];
      err <= err || err_set;
    end
  end
  always_ff @(posedge clk) begin
    if (ldbuf_wr_en) ldbuf[ldbuf_wr_addr] <= ldbuf_wr_data;
    if (state == ST_STORE && vpu_store_valid) stbuf[k[AW-1:0]] <= vpu_store_data;
    if (push) begin
      q_sbid[wr_ptr] <= sbid;
      q_vl[wr_ptr] <= core_issue_vl;
      q_sew[wr_ptr] <= core_issue_sew;
      q_vreg[wr_ptr] <= core_issue_instr[11:7];
      q_st[wr_ptr] <= is_store;
    end
  end
endmodule

// File: tb/tb_ovi_memop_bridge.sv
// tb_ovi_memop_bridge: directed self-checking bench for ovi_memop_bridge
module tb_ovi_memop_bridge;
  localparam int MW = 512;
  localparam int SW = 5;
  localparam int VW = 15;
  localparam int AW = 5;
  localparam logic [31:0] LD5 = 32'h0000_0287;
  localparam logic [31:0] ST3 = 32'h0000_01A7;
  localparam logic [31:0] VOP = 32'h0000_0057;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic core_issue_valid = 1'b0;
  logic [31:0] core_issue_instr = '0;
  logic [VW-1:0] core_issue_vl = '0;
  logic [1:0] core_issue_sew = '0;
  logic [63:0] core_issue_scalar = '0;
  logic core_halt, core_completed_valid;
  logic [63:0] core_completed_data;
  logic vpu_issue_valid;
  logic [31:0] vpu_issue_instr;
  logic [63:0] vpu_issue_scalar;
  logic [SW-1:0] vpu_issue_sbid, vpu_dispatch_sbid, vpu_memop_sbid, vpu_load_sbid;
  logic [VW-1:0] vpu_issue_vl;
  logic [1:0] vpu_issue_sew;
  logic vpu_issue_credit = 1'b0;
  logic vpu_dispatch_next_senior;
  logic vpu_completed_valid = 1'b0;
  logic [63:0] vpu_completed_data = '0;
  logic vpu_sync_start = 1'b0;
  logic vpu_memop_sync_end, vpu_load_valid;
  logic [MW-1:0] vpu_load_data;
  logic [4:0] vpu_load_vreg;
  logic [10:0] vpu_load_el_id;
  logic [6:0] vpu_load_el_count;
  logic vpu_store_valid = 1'b0;
  logic [MW-1:0] vpu_store_data = '0;
  logic vpu_store_credit;
  logic ldbuf_wr_en = 1'b0;
  logic [AW-1:0] ldbuf_wr_addr = '0;
  logic [MW-1:0] ldbuf_wr_data = '0;
  logic [AW-1:0] stbuf_rd_addr = '0;
  logic [MW-1:0] stbuf_rd_data;
  logic memop_done, err;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  ovi_memop_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .core_issue_valid(core_issue_valid), .core_issue_instr(core_issue_instr),
    .core_issue_vl(core_issue_vl), .core_issue_sew(core_issue_sew),
    .core_issue_scalar(core_issue_scalar), .core_halt(core_halt),
    .core_completed_valid(core_completed_valid), .core_completed_data(core_completed_data),
    .vpu_issue_valid(vpu_issue_valid), .vpu_issue_instr(vpu_issue_instr),
    .vpu_issue_scalar(vpu_issue_scalar), .vpu_issue_sbid(vpu_issue_sbid),
    .vpu_issue_vl(vpu_issue_vl), .vpu_issue_sew(vpu_issue_sew),
    .vpu_issue_credit(vpu_issue_credit), .vpu_dispatch_next_senior(vpu_dispatch_next_senior),
    .vpu_dispatch_sbid(vpu_dispatch_sbid), .vpu_completed_valid(vpu_completed_valid),
    .vpu_completed_data(vpu_completed_data), .vpu_sync_start(vpu_sync_start),
    .vpu_memop_sync_end(vpu_memop_sync_end), .vpu_memop_sbid(vpu_memop_sbid),
    .vpu_load_valid(vpu_load_valid), .vpu_load_data(vpu_load_data),
    .vpu_load_vreg(vpu_load_vreg), .vpu_load_el_id(vpu_load_el_id),
    .vpu_load_el_count(vpu_load_el_count), .vpu_load_sbid(vpu_load_sbid),
    .vpu_store_valid(vpu_store_valid), .vpu_store_data(vpu_store_data),
    .vpu_store_credit(vpu_store_credit), .ldbuf_wr_en(ldbuf_wr_en),
    .ldbuf_wr_addr(ldbuf_wr_addr), .ldbuf_wr_data(ldbuf_wr_data),
    .stbuf_rd_addr(stbuf_rd_addr), .stbuf_rd_data(stbuf_rd_data),
    .memop_done(memop_done), .err(err)
  );
  function automatic logic [MW-1:0] pat(input logic [31:0] s);
    return {(MW/32){s}};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] instr, input int vl, input logic [1:0] sew, input bit ret);
    core_issue_valid = 1'b1;
    core_issue_instr = instr;
    core_issue_vl = VW'(vl);
    core_issue_sew = sew;
    step();
    core_issue_valid = 1'b0;
    if (ret) begin
      vpu_issue_credit = 1'b1;
      step();
      vpu_issue_credit = 1'b0;
    end
  endtask
  task automatic test_reset();
    int pulses;
    logic first;
    pulses = 0;
    first = 1'b0;
    step();
    step();
    #2;
    checks++;
    if ({vpu_issue_valid, vpu_store_credit, err, vpu_memop_sync_end, vpu_load_valid, memop_done, core_halt, core_completed_valid} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000000", {vpu_issue_valid, vpu_store_credit, err, vpu_memop_sync_end, vpu_load_valid, memop_done, core_halt, core_completed_valid});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      #2;
      if (i == 0) first = vpu_store_credit;
      if (vpu_store_credit) pulses++;
    end
    checks++;
    if (first !== 1'b1) begin errors++; $display("FAIL reset_first_credit: got %b want 1", first); end
    checks++;
    if (pulses != 4) begin errors++; $display("FAIL reset_credit_pulses: got %0d want 4", pulses); end
  endtask
  task automatic test_load();
    for (int i = 0; i < 3; i++) begin
      ldbuf_wr_en = 1'b1;
      ldbuf_wr_addr = AW'(i);
      ldbuf_wr_data = pat(32'hA0 + i);
      step();
    end
    ldbuf_wr_en = 1'b0;
    core_issue_valid = 1'b1;
    core_issue_instr = LD5;
    core_issue_vl = VW'(40);
    core_issue_sew = 2'd2;
    core_issue_scalar = 64'hDEAD_BEEF_0000_0001;
    #2;
    checks++;
    if ({vpu_issue_valid, vpu_dispatch_next_senior, vpu_issue_sbid, vpu_issue_vl} !== {2'b11, 5'd0, 15'd40}) begin
      errors++;
      $display("FAIL load_issue: got v=%b d=%b sbid=%0d vl=%0d want 1 1 0 40", vpu_issue_valid, vpu_dispatch_next_senior, vpu_issue_sbid, vpu_issue_vl);
    end
    checks++;
    if (vpu_issue_scalar !== 64'hDEAD_BEEF_0000_0001) begin errors++; $display("FAIL load_scalar: got %h want deadbeef00000001", vpu_issue_scalar); end
    step();
    core_issue_valid = 1'b0;
    vpu_issue_credit = 1'b1;
    step();
    vpu_issue_credit = 1'b0;
    vpu_sync_start = 1'b1;
    #2;
    checks++;
    if (vpu_load_valid !== 1'b0) begin errors++; $display("FAIL load_early_valid: got %b want 0", vpu_load_valid); end
    step();
    vpu_sync_start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      if (b == 1) begin
        ldbuf_wr_en = 1'b1;
        ldbuf_wr_addr = AW'(1);
        ldbuf_wr_data = pat(32'hFF);
      end
      #2;
      checks++;
      if ({vpu_load_valid, vpu_load_el_id, vpu_load_el_count, vpu_load_vreg, vpu_load_sbid} !== {1'b1, 11'(b * 16), 7'(b == 2 ? 8 : 16), 5'd5, 5'd0}) begin
        errors++;
        $display("FAIL load_beat%0d: got v=%b id=%0d cnt=%0d vreg=%0d sbid=%0d want 1 %0d %0d 5 0", b, vpu_load_valid, vpu_load_el_id, vpu_load_el_count, vpu_load_vreg, vpu_load_sbid, b * 16, b == 2 ? 8 : 16);
      end
      checks++;
      if (vpu_load_data !== pat(32'hA0 + b)) begin errors++; $display("FAIL load_data%0d: got %h want word %h", b, vpu_load_data[31:0], 32'hA0 + b); end
      step();
      ldbuf_wr_en = 1'b0;
    end
    #2;
    checks++;
    if ({vpu_memop_sync_end, memop_done, vpu_memop_sbid, vpu_load_valid} !== {2'b11, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL load_end: got end=%b done=%b sbid=%0d lv=%b want 1 1 0 0", vpu_memop_sync_end, memop_done, vpu_memop_sbid, vpu_load_valid);
    end
    step();
    #2;
    checks++;
    if (vpu_memop_sync_end !== 1'b0) begin errors++; $display("FAIL load_end_once: got %b want 0", vpu_memop_sync_end); end
  endtask
  task automatic test_completion();
    vpu_completed_valid = 1'b1;
    vpu_completed_data = 64'h1234_5678_9ABC_DEF0;
    #2;
    checks++;
    if (core_completed_valid !== 1'b0) begin errors++; $display("FAIL compl_early: got %b want 0", core_completed_valid); end
    step();
    vpu_completed_valid = 1'b0;
    #2;
    checks++;
    if ({core_completed_valid, core_completed_data} !== {1'b1, 64'h1234_5678_9ABC_DEF0}) begin
      errors++;
      $display("FAIL compl_reg: got %b %h want 1 123456789abcdef0", core_completed_valid, core_completed_data);
    end
    step();
  endtask
  task automatic test_store();
    issue(ST3, 16, 2'd3, 1'b1);
    vpu_sync_start = 1'b1;
    step();
    vpu_sync_start = 1'b0;
    vpu_store_valid = 1'b1;
    vpu_store_data = pat(32'h5100);
    #2;
    checks++;
    if (vpu_memop_sync_end !== 1'b0) begin errors++; $display("FAIL store_early_end: got %b want 0", vpu_memop_sync_end); end
    step();
    vpu_store_data = pat(32'h5101);
    #2;
    checks++;
    if (vpu_store_credit !== 1'b1) begin errors++; $display("FAIL store_credit0: got %b want 1", vpu_store_credit); end
    step();
    vpu_store_valid = 1'b0;
    #2;
    checks++;
    if ({vpu_memop_sync_end, memop_done, vpu_memop_sbid, vpu_store_credit} !== {2'b11, 5'd1, 1'b1}) begin
      errors++;
      $display("FAIL store_end: got end=%b done=%b sbid=%0d cr=%b want 1 1 1 1", vpu_memop_sync_end, memop_done, vpu_memop_sbid, vpu_store_credit);
    end
    step();
    #2;
    checks++;
    if ({vpu_store_credit, vpu_memop_sync_end, err} !== 3'b000) begin
      errors++;
      $display("FAIL store_after: got cr=%b end=%b err=%b want 0 0 0", vpu_store_credit, vpu_memop_sync_end, err);
    end
    stbuf_rd_addr = AW'(0);
    step();
    #2;
    checks++;
    if (stbuf_rd_data !== pat(32'h5100)) begin errors++; $display("FAIL stbuf0: got word %h want 5100", stbuf_rd_data[31:0]); end
    stbuf_rd_addr = AW'(1);
    step();
    #2;
    checks++;
    if (stbuf_rd_data !== pat(32'h5101)) begin errors++; $display("FAIL stbuf1: got word %h want 5101", stbuf_rd_data[31:0]); end
  endtask
  task automatic test_boundary();
    int vls [2] = '{32, 64};
    for (int i = 0; i < 2; i++) begin
      issue(LD5, vls[i], 2'd0, 1'b1);
      vpu_sync_start = 1'b1;
      step();
      vpu_sync_start = 1'b0;
      #2;
      checks++;
      if ({vpu_load_valid, vpu_load_el_id, vpu_load_el_count} !== {1'b1, 11'd0, 7'(vls[i])}) begin
        errors++;
        $display("FAIL bound_vl%0d: got v=%b id=%0d cnt=%0d want 1 0 %0d", vls[i], vpu_load_valid, vpu_load_el_id, vpu_load_el_count, vls[i]);
      end
      step();
      #2;
      checks++;
      if ({vpu_memop_sync_end, vpu_load_valid, vpu_memop_sbid} !== {2'b10, 5'(2 + i)}) begin
        errors++;
        $display("FAIL bound_end_vl%0d: got end=%b lv=%b sbid=%0d want 1 0 %0d", vls[i], vpu_memop_sync_end, vpu_load_valid, vpu_memop_sbid, 2 + i);
      end
      step();
    end
    issue(LD5, 0, 2'd2, 1'b1);
    vpu_sync_start = 1'b1;
    step();
    vpu_sync_start = 1'b0;
    #2;
    checks++;
    if ({vpu_memop_sync_end, vpu_load_valid, vpu_memop_sbid} !== {2'b10, 5'd4}) begin
      errors++;
      $display("FAIL bound_vl0: got end=%b lv=%b sbid=%0d want 1 0 4", vpu_memop_sync_end, vpu_load_valid, vpu_memop_sbid);
    end
    step();
  endtask
  task automatic test_queue_wrap();
    for (int i = 0; i < 4; i++) issue(LD5, 0, 2'd0, 1'b0);
    vpu_issue_credit = 1'b1;
    step();
    vpu_issue_credit = 1'b0;
    #2;
    checks++;
    if (core_halt !== 1'b1) begin errors++; $display("FAIL queue_full_halt: got %b want 1", core_halt); end
    for (int j = 0; j < 4; j++) begin
      vpu_sync_start = 1'b1;
      step();
      vpu_sync_start = 1'b0;
      #2;
      checks++;
      if ({vpu_memop_sync_end, vpu_memop_sbid} !== {1'b1, 5'(5 + j)}) begin
        errors++;
        $display("FAIL queue_order%0d: got end=%b sbid=%0d want 1 %0d", j, vpu_memop_sync_end, vpu_memop_sbid, 5 + j);
      end
      step();
    end
    #2;
    checks++;
    if (core_halt !== 1'b0) begin errors++; $display("FAIL queue_drained_halt: got %b want 0", core_halt); end
    vpu_issue_credit = 1'b1;
    repeat (3) step();
    core_issue_valid = 1'b1;
    core_issue_instr = VOP;
    repeat (22) step();
    #2;
    checks++;
    if (vpu_issue_sbid !== 5'd31) begin errors++; $display("FAIL wrap_31: got %0d want 31", vpu_issue_sbid); end
    step();
    #2;
    checks++;
    if ({vpu_issue_valid, vpu_issue_sbid} !== {1'b1, 5'd0}) begin errors++; $display("FAIL wrap_0: got v=%b sbid=%0d want 1 0", vpu_issue_valid, vpu_issue_sbid); end
    step();
    core_issue_valid = 1'b0;
    vpu_issue_credit = 1'b0;
    #2;
    checks++;
    if ({core_halt, err} !== 2'b00) begin errors++; $display("FAIL wrap_credits: got halt=%b err=%b want 0 0", core_halt, err); end
  endtask
  task automatic test_credit();
    core_issue_valid = 1'b1;
    core_issue_instr = VOP;
    repeat (4) step();
    #2;
    checks++;
    if ({core_halt, vpu_issue_valid, vpu_dispatch_next_senior} !== 3'b100) begin
      errors++;
      $display("FAIL credit_fifth_held: got halt=%b v=%b d=%b want 1 0 0", core_halt, vpu_issue_valid, vpu_dispatch_next_senior);
    end
    step();
    core_issue_valid = 1'b0;
    vpu_issue_credit = 1'b1;
    step();
    vpu_issue_credit = 1'b0;
    #2;
    checks++;
    if (core_halt !== 1'b0) begin errors++; $display("FAIL credit_one_back: got halt=%b want 0", core_halt); end
    core_issue_valid = 1'b1;
    vpu_issue_credit = 1'b1;
    #1;
    checks++;
    if (vpu_issue_valid !== 1'b1) begin errors++; $display("FAIL credit_same_issue: got %b want 1", vpu_issue_valid); end
    step();
    core_issue_valid = 1'b0;
    vpu_issue_credit = 1'b0;
    #2;
    checks++;
    if (core_halt !== 1'b0) begin errors++; $display("FAIL credit_unchanged: got halt=%b want 0", core_halt); end
    core_issue_valid = 1'b1;
    step();
    core_issue_valid = 1'b0;
    #2;
    checks++;
    if (core_halt !== 1'b1) begin errors++; $display("FAIL credit_empty_again: got halt=%b want 1", core_halt); end
    vpu_issue_credit = 1'b1;
    repeat (4) step();
    #2;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL credit_refill_err: got %b want 0", err); end
    step();
    vpu_issue_credit = 1'b0;
    #2;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL credit_overflow_err: got %b want 1", err); end
  endtask
  task automatic test_reset_mid_store();
    int pulses;
    pulses = 0;
    issue(ST3, 16, 2'd3, 1'b1);
    vpu_sync_start = 1'b1;
    step();
    vpu_sync_start = 1'b0;
    vpu_store_valid = 1'b1;
    vpu_store_data = pat(32'h7700);
    step();
    vpu_store_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({vpu_store_credit, err, core_halt, vpu_memop_sync_end, memop_done} !== 5'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got cr=%b err=%b halt=%b end=%b done=%b want 0 0 0 0 0", vpu_store_credit, err, core_halt, vpu_memop_sync_end, memop_done);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      #2;
      if (vpu_store_credit) pulses++;
      checks++;
      if (vpu_memop_sync_end !== 1'b0) begin errors++; $display("FAIL midrst_no_end%0d: got %b want 0", i, vpu_memop_sync_end); end
    end
    checks++;
    if (pulses != 4) begin errors++; $display("FAIL midrst_credit_pulses: got %0d want 4", pulses); end
    vpu_store_valid = 1'b1;
    step();
    vpu_store_valid = 1'b0;
    #2;
    checks++;
    if ({err, vpu_store_credit} !== 2'b11) begin errors++; $display("FAIL stray_store: got err=%b cr=%b want 1 1", err, vpu_store_credit); end
    vpu_sync_start = 1'b1;
    step();
    vpu_sync_start = 1'b0;
    #2;
    checks++;
    if ({vpu_memop_sync_end, vpu_load_valid} !== 2'b00) begin errors++; $display("FAIL empty_sync: got end=%b lv=%b want 0 0", vpu_memop_sync_end, vpu_load_valid); end
    core_issue_valid = 1'b1;
    core_issue_instr = VOP;
    #1;
    checks++;
    if (vpu_issue_sbid !== 5'd0) begin errors++; $display("FAIL midrst_sbid: got %0d want 0", vpu_issue_sbid); end
    repeat (3) step();
    #2;
    checks++;
    if (core_halt !== 1'b0) begin errors++; $display("FAIL midrst_credits3: got halt=%b want 0", core_halt); end
    step();
    core_issue_valid = 1'b0;
    #2;
    checks++;
    if (core_halt !== 1'b1) begin errors++; $display("FAIL midrst_credits4: got halt=%b want 1", core_halt); end
  endtask
  initial begin
    test_reset();
    test_load();
    test_completion();
    test_store();
    test_boundary();
    test_queue_wrap();
    test_credit();
    test_reset_mid_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ovi_memop_bridge.md
Name: ovi_memop_bridge

Overview:
Parametrised core-to-VPU OVI bridge: issues vector instructions under credit flow control, tracks up to PEND_DEPTH outstanding memops in order, and moves unit-stride load/store data between core-visible buffers and the VPU load/store buses. Sits between the scalar core issue stage and the VPU OVI port.

Parameters:
MEMDATA_W, 512, OVI load/store beat width in bits (power of 2, >=64)
SBID_W, 5, scoreboard id width
VL_W, 15, vl field width
ISSUE_CREDITS, 4, VPU issue credits at reset
STORE_CREDITS, 4, store credits granted to VPU at reset
BUF_DEPTH, 32, load/store buffer depth in beats (power of 2); AW = log2(BUF_DEPTH)
PEND_DEPTH, 4, outstanding memop queue depth (power of 2)

Ports:
CLK in 1 clock; RST_N in 1 asynchronous active-low reset (one clock domain).
CORE_ISSUE_VALID/INSTR/VL/SEW/SCALAR in 1/32/VL_W/2/64: core issue request; accepted when VALID && !CORE_HALT.
CORE_HALT out 1: core must hold its issue.
CORE_COMPLETED_VALID/DATA out 1/64: registered copy of VPU completion.
VPU_ISSUE_VALID/INSTR/SCALAR/SBID/VL/SEW out 1/32/64/SBID_W/VL_W/2: OVI issue.
VPU_ISSUE_CREDIT in 1: one credit returned per cycle high.
VPU_DISPATCH_NEXT_SENIOR/SBID out 1/SBID_W: dispatch, equal to issue this block.
VPU_COMPLETED_VALID/DATA in 1/64.
VPU_SYNC_START in 1: VPU ready for data of oldest pending memop.
VPU_MEMOP_SYNC_END/SBID out 1/SBID_W.
VPU_LOAD_VALID/DATA/VREG/EL_ID/EL_COUNT/SBID out 1/MEMDATA_W/5/11/7/SBID_W.
VPU_STORE_VALID/DATA in 1/MEMDATA_W; VPU_STORE_CREDIT out 1 (pulse per credit returned).
LDBUF_WR_EN/ADDR/DATA in 1/AW/MEMDATA_W: core fills load buffer.
STBUF_RD_ADDR in AW; STBUF_RD_DATA out MEMDATA_W (1-cycle read latency).
MEMOP_DONE out 1 pulse per completed memop transfer; ERR out 1 sticky protocol error.

Behaviour:
- Reset: all outputs 0; credits=ISSUE_CREDITS, sbid=0, queue empty, state IDLE; buffer contents not reset. Reset mid-transfer abandons it; no sync_end.
- CORE_HALT = (credits==0) || queue full. Accept: VPU_ISSUE_VALID=1 same cycle (combinational pass of instr/vl/sew/scalar), sbid++ (wraps mod 2^SBID_W), credits--.
- Memop decode: INSTR[6:0]==0000111 load, 0100111 store; memops push {sbid,vl,sew,vreg=INSTR[11:7],is_store} into queue; others do not.
- Credit: consume and VPU_ISSUE_CREDIT same cycle -> unchanged; return at ISSUE_CREDITS -> saturate, ERR=1.
- Completion: CORE_COMPLETED registered, 1-cycle latency.
- Beat math: ebits=8<<sew; EPB=MEMDATA_W/ebits; n=ceil(vl*ebits/MEMDATA_W); beat k: EL_ID=k*EPB, EL_COUNT = (k==n-1) ? vl-(n-1)*EPB : EPB (exact multiple yields EPB, never 0). n>BUF_DEPTH -> n clamped to BUF_DEPTH, ERR=1.
- FSM IDLE/LOAD/STORE/END. IDLE: SYNC_START with queue non-empty -> LOAD or STORE per head, beat counter=0; SYNC_START with empty queue -> ERR, stay.
- LOAD: one beat per cycle, VALID=1, DATA=LDBUF[k], no backpressure; after beat n-1 -> END. vl=0 -> straight to END.
- STORE: each VPU_STORE_VALID writes STBUF[k], k++; VPU_STORE_CREDIT pulses next cycle per beat; store beat outside STORE -> ERR, discarded, credit still returned. k==n -> END.
- Store credit: STORE_CREDITS pulses, one per cycle, in first cycles after reset; never more than STORE_CREDITS outstanding.
- END: one cycle SYNC_END=1, MEMOP_SBID=head sbid, MEMOP_DONE=1, pop queue -> IDLE. Issue can push same cycle as pop.
- LDBUF write port independent; same-address write during LOAD read returns old data.

Test Plan:
- Load sew=2 (32b), vl=40, MEMDATA_W=512: 3 beats, EL_ID 0/16/32, EL_COUNT 16/16/8, SYNC_END cycle after last beat.
- Store sew=3, vl=16: 2 beats captured, STBUF[0..1] match, 2 credit pulses, one MEMOP_DONE.
- vl=32 sew=0: one beat EL_COUNT=32 (not 0); vl=0: SYNC_END one cycle after SYNC_START, no LOAD_VALID.
- Issue 5 instr with 4 credits, no returns: 5th halted; return credit same cycle as issue -> count unchanged; return at full -> ERR.
- 4 memops queued (PEND_DEPTH=4): CORE_HALT=1; SYNC_END ids in issue order; sbid wraps 31->0.
- Assert RST_N mid-store: outputs 0 immediately, credits=4, queue empty, fresh store credit pulses after release.
